// File: rtl/riscv_muldiv_unit_if.sv
// Issue and writeback handshake bundle for the iterative RV32M multiply/divide unit.
// The master side belongs to issue/writeback; the slave side belongs to the unit.
interface riscv_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_func;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_func, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_func, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide,
// one result bit per cycle, with a valid/ready result port and a pipeline flush.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  riscv_muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } func_t;

  state_t             state;
  func_t              func_q;
  logic               neg_ab;    // product / quotient must be negated
  logic               neg_a;     // remainder must be negated
  logic [XLEN-1:0]    b_mag;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    quo;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN-1:0]    result_q;
  logic [TAG_W-1:0]   tag_q;

  // Accept-side decode
  func_t              in_f;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]    a_mag_in, b_mag_in;
  logic               div_zero, div_ovf;
  logic [XLEN-1:0]    special_res;

  // NOTE: every always_comb output gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    in_f        = func_t'(bus.in_func);
    a_signed    = (in_f == F_MULH) || (in_f == F_MULHSU) || (in_f == F_DIV) || (in_f == F_REM);
    b_signed    = (in_f == F_MULH) || (in_f == F_DIV) || (in_f == F_REM);
    a_neg       = a_signed && bus.in_a[XLEN-1];
    b_neg       = b_signed && bus.in_b[XLEN-1];
    a_mag_in    = a_neg ? -bus.in_a : bus.in_a;
    b_mag_in    = b_neg ? -bus.in_b : bus.in_b;
    div_zero    = in_f[2] && (bus.in_b == '0);
    div_ovf     = in_f[2] && !in_f[0] && (bus.in_a == INT_MIN) && (bus.in_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = in_f[1] ? bus.in_a : '1;
    else if (div_ovf)
      special_res = in_f[1] ? '0 : bus.in_a;
  end

  // One iteration of each datapath; the divider works on an XLEN+1 bit partial remainder
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  acc_nx;
  logic [XLEN:0]      div_shift;
  logic [XLEN:0]      div_diff;
  logic [XLEN-1:0]    rem_nx;
  logic [XLEN-1:0]    quo_nx;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_nx    = {mul_sum, acc[XLEN-1:1]};
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    // A borrow out of the top bit means the divisor did not fit: restore.
    rem_nx    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    quo_nx    = {quo[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Sign fixup and result selection, applied on the final iteration
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix;
  logic [XLEN-1:0]    rem_fix;
  logic [XLEN-1:0]    final_res;

  always_comb begin
    prod_fix  = neg_ab ? -acc_nx : acc_nx;
    quo_fix   = neg_ab ? -quo_nx : quo_nx;
    rem_fix   = neg_a  ? -rem_nx : rem_nx;
    final_res = '0;
    unique case (func_q)
      F_MUL:                    final_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:            final_res = quo_fix;
      default:                  final_res = rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      func_q   <= F_MUL;
      neg_ab   <= 1'b0;
      neg_a    <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            func_q <= in_f;
            neg_ab <= a_neg ^ b_neg;
            neg_a  <= a_neg;
            b_mag  <= b_mag_in;
            acc    <= {{XLEN{1'b0}}, a_mag_in};
            rem    <= '0;
            quo    <= a_mag_in;
            cnt    <= CNT_W'(XLEN);
            tag_q  <= bus.in_tag;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (func_q[2]) begin
            rem <= rem_nx;
            quo <= quo_nx;
          end else begin
            acc <= acc_nx;
          end
          if (cnt == CNT_W'(1)) begin
            result_q <= final_res;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: scoreboard of expected results built
// from a 64-bit arithmetic reference model, compared when the unit presents a result.
module tb_riscv_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  typedef struct {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;

  exp_t exp_q[$];

  riscv_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  // Present an op at the falling edge; it is accepted on the following rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    exp_t e;
    @(negedge clk);
    bus.in_func  = f;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b expected 1 (func=%0d)", bus.in_ready, f);
    end
    @(posedge clk);
    e.result = model(f, a, b);
    e.tag    = tag;
    e.lat    = model_lat(f, a, b);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result (edges counted from the accept edge as 1), compare, then
  // optionally hold off writeback for `hold` cycles before completing the handshake.
  task automatic collect(input int hold);
    int               lat;
    exp_t             e;
    logic [XLEN-1:0]  r0;
    logic [TAG_W-1:0] t0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result seen with no expected entry");
      return;
    end
    e = exp_q.pop_front();
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL latency: got %0d edges expected %0d", lat, e.lat);
    end
    checks++;
    if (bus.out_result !== e.result) begin
      errors++;
      $display("FAIL result: got %h expected %h", bus.out_result, e.result);
    end
    checks++;
    if (bus.out_tag !== e.tag) begin
      errors++;
      $display("FAIL tag: got %0d expected %0d", bus.out_tag, e.tag);
    end
    r0 = e.result;
    t0 = e.tag;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== r0 || bus.out_tag !== t0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b result=%h tag=%0d in_ready=%b expected 1/%h/%0d/0",
                 i, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready, r0, t0);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_idle: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    issue(f, a, b, tag);
    collect(0);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h tag=%0d expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
    end
  endtask

  task automatic test_mul;
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd1, 32'hFFFF_FFF9, 32'd3,         5'd4);
  endtask

  task automatic test_div;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7);
    run_op(3'd5, 32'd100,       32'd7,         5'd8);
    run_op(3'd7, 32'd100,       32'd7,         5'd9);
    run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 5'd10);
    run_op(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd11);
  endtask

  task automatic test_special;
    run_op(3'd5, 32'd1234,      32'd0,         5'd12);
    run_op(3'd6, 32'd13,        32'd0,         5'd13);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0,         5'd16);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd0,         5'd17);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18);
  endtask

  task automatic test_backpressure;
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd19);
    collect(10);
  endtask

  task automatic test_back_to_back;
    logic [31:0] corners [6];
    logic [31:0] a, b;
    logic [2:0]  f;
    exp_t        e;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};
    // An op held on in_valid during the result handshake must not be taken that edge.
    issue(3'd1, 32'h0001_0000, 32'hFFFF_0000, 5'd20);
    while (bus.out_valid !== 1'b1) @(posedge clk);
    @(negedge clk);
    bus.in_func  = 3'd5;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd9;
    bus.in_tag   = 5'd21;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (bus.out_result !== e.result) begin
      errors++;
      $display("FAIL b2b_first_result: got %h expected %h", bus.out_result, e.result);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_accept_in_done: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    e.result = model(3'd5, 32'd1000, 32'd9);
    e.tag    = 5'd21;
    e.lat    = model_lat(3'd5, 32'd1000, 32'd9);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    collect(0);
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 1) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(f, a, b, 5'(i + 1));
    end
  endtask

  task automatic test_flush;
    int seen;
    // Flush mid-divide: unit idles next edge, no result ever appears.
    issue(3'd4, 32'd1000, 32'd3, 5'd22);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid high %0d cycles expected 0", seen);
    end
    run_op(3'd0, 32'd12345, 32'd678, 5'd23);
    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.in_func  = 3'd0;
    bus.in_a     = 32'd2;
    bus.in_b     = 32'd3;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_accept: in_ready=%b expected 1", bus.in_ready);
    end
    // Flush in DONE discards the held result.
    issue(3'd7, 32'd50, 32'd0, 5'd24);
    void'(exp_q.pop_back());
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_pre: out_valid=%b expected 1", bus.out_valid);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset;
    issue(3'd0, 32'd9, 32'd9, 5'd25);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h tag=%0d expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd26);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_func   = 3'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Iterative RV32M execute unit. Takes decoded M-extension operations from the decode/issue stage: opcode RTYPE, funct7 = 0000001, m_func codes MUL..REMU.
- Computes one result bit per cycle using radix-2 shift-add (multiply) and restoring shift-subtract (divide).
- Returns the result to writeback over a valid/ready handshake.
- Sits beside the single-cycle ALU in the execute stage. Issue stalls on in_ready.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the destination-register tag carried through (rd).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any op in flight (branch mispredict/trap)
- in_valid  in  1  issue presents an op
- in_ready  out  1  unit can accept (high only in IDLE)
- in_func  in  3  instr[14:12] of the M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- in_tag  in  TAG_W  rd index
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  rd index of the result

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; out_result = 0; out_tag = 0.
  - Iteration counter and internal registers are cleared.
- IDLE:
  - An op is accepted on the edge where in_valid && in_ready. in_func, the operand signs, the magnitudes of in_a and in_b, and in_tag are latched.
  - Signed operands: MULH/DIV/REM treat both operands as signed. MULHSU treats in_a as signed and in_b as unsigned. MUL's low word is sign-agnostic and computed unsigned.
  - Next state is BUSY, with the counter set to XLEN.
  - Exception: special divide cases go directly to DONE, with the result valid 1 edge after acceptance.
- Special divide cases:
  - Divide by zero (in_b == 0): DIV/DIVU -> all ones; REM/REMU -> in_a.
  - Signed overflow (DIV/REM with in_a = 0x80000000 and in_b = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- BUSY:
  - One iteration per cycle; the counter decrements.
  - Multiply keeps a 2*XLEN accumulator.
  - Divide keeps an XLEN+1 partial remainder and an XLEN quotient.
  - When the counter reaches 1, the final iteration completes and the state moves to DONE on that edge.
  - In the same edge, the sign fixup is applied (two's-complement negate of product, quotient or remainder as required) and out_result is selected:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN signed-corrected product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Sign rules: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
- Latency: out_valid rises exactly XLEN+1 rising edges after the acceptance edge (33 for XLEN=32). Special divide cases take 1 edge.
- DONE:
  - out_valid = 1; out_result and out_tag are held stable while out_ready = 0.
  - On an edge with out_ready = 1, the state returns to IDLE and out_valid drops.
  - No back-to-back accept: in_ready = 0 in DONE, so the next op is accepted at the earliest 1 cycle after the result handshake.
- flush:
  - In BUSY or DONE, the next edge forces IDLE and out_valid = 0. A result held in DONE is discarded.
  - Flush has priority over the out handshake and over in acceptance. With flush high in IDLE, no op is accepted that edge.
- Registered outputs: in_ready is a decode of state; out_result and out_tag are registers.
- in_func values are always legal (3-bit full encoding). No illegal-op handling.

Test Plan:
- MUL 7 * -3 (in_b = 0xFFFFFFFD) -> out_result 0xFFFFFFEB; out_valid 33 edges after accept; out_tag echoes in_tag = 5.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF (-1) * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU x / 0 -> 0xFFFFFFFF; REM 13 % 0 -> 13; DIV 0x80000000 / -1 -> 0x80000000. Each with out_valid 1 edge after accept.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> result and tag stable, in_ready stays 0; raise out_ready -> IDLE next edge, in_ready = 1.
- Flush at iteration 12 of a DIV -> IDLE next edge, no out_valid. A new MUL is then accepted and completes correctly. Assert rst_n low mid-BUSY -> all outputs reset asynchronously, before the next clock edge.
